// File: rtl/risk_ctrl_if.sv
// Command and tile-bus interface of risk_ctrl.
// The producer side uses the master modport; the controller uses the slave modport.
interface risk_ctrl_if #(
    parameter int LOGCNT = 5
);
    localparam int AW = 10 + LOGCNT;
    localparam int SW = 9 + LOGCNT;

    // Command push side
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_func;
    logic [4:0]    cmd_reg;
    logic [AW-1:0] cmd_addr;
    logic [SW-1:0] cmd_stride_x;
    logic [SW-1:0] cmd_stride_y;

    // Tile-unit side
    logic [2:0]    risk_func;
    logic [4:0]    risk_reg;
    logic [AW-1:0] risk_addr;
    logic [SW-1:0] risk_stride_x;
    logic [SW-1:0] risk_stride_y;

    // Status
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output cmd_valid, cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y,
        input  cmd_ready,
        input  risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y,
        input  busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y,
        output cmd_ready,
        output risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y,
        output busy, done, err
    );
endinterface

// File: rtl/risk_ctrl.sv
// risk_ctrl: queues tile load/store/zero commands in a small FIFO and issues
// them to the tile unit. Loads and zeros issue back-to-back; a store is
// followed by one NOP cycle (tile-memory write enable) before the next issue.
// Invalid commands are dropped with an err pulse; each issued command gets a
// done pulse the cycle after it appears on the bus.
module risk_ctrl #(
    parameter int SZ     = 4,
    parameter int LOGCNT = 5,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    risk_ctrl_if.slave bus
);
    localparam int AW = 10 + LOGCNT;
    localparam int SW = 9 + LOGCNT;
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    localparam logic [2:0] FUNC_LOAD  = 3'b000;
    localparam logic [2:0] FUNC_STORE = 3'b001;
    localparam logic [2:0] FUNC_ZERO  = 3'b010;
    localparam logic [2:0] FUNC_NOP   = 3'b111;

    typedef struct packed {
        logic [2:0]    func;
        logic [4:0]    rg;
        logic [AW-1:0] addr;
        logic [SW-1:0] stride_x;
        logic [SW-1:0] stride_y;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STORE_HOLD
    } state_t;

    if (SZ < 1 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
        $error("risk_ctrl: SZ must be >= 1 and DEPTH a power of two in 2..16");
    end

    function automatic logic cmd_is_valid(input cmd_t c);
        return ((c.func == FUNC_LOAD) || (c.func == FUNC_STORE) || (c.func == FUNC_ZERO))
               && (c.rg <= 5'd2);
    endfunction

    cmd_t          fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    cmd_t          in_cmd;
    cmd_t          head;
    logic          head_ok;

    state_t        state;
    state_t        state_nxt;
    cmd_t          cur;        // command popped and waiting to be driven onto the bus
    logic          load_cur;
    logic          issue;
    logic          err_nxt;

    assign in_cmd = '{func:     bus.cmd_func,
                      rg:       bus.cmd_reg,
                      addr:     bus.cmd_addr,
                      stride_x: bus.cmd_stride_x,
                      stride_y: bus.cmd_stride_y};

    assign bus.cmd_ready = (count < DEPTH_C);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign fifo_empty    = (count == '0);
    assign head          = fifo_mem[rd_ptr];
    assign head_ok       = cmd_is_valid(head);
    assign bus.busy      = !fifo_empty || (state != IDLE);

    // FIFO storage: the tail entry is written on every accepted command.
    // NOTE: sequential logic uses <= so every register samples pre-edge values.
    // NOTE: the storage array has no reset; pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_cmd;
        end
    end

    // FIFO pointers, occupancy, FSM state and the staged command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
            cur    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            state <= state_nxt;
            if (load_cur) cur <= head;
        end
    end

    // Next-state and pop/issue decisions. A command only reaches the FIFO
    // head one cycle after its push, so there is no bypass path.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_cur  = 1'b0;
        issue     = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        load_cur  = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (cur.func == FUNC_STORE) begin
                    state_nxt = STORE_HOLD;
                end else if (!fifo_empty && head_ok) begin
                    pop      = 1'b1;
                    load_cur = 1'b1;
                end else begin
                    // Empty, or an invalid head that IDLE will drop.
                    state_nxt = IDLE;
                end
            end
            STORE_HOLD: begin
                // Bus shows NOP this edge; the next valid command may be staged.
                if (!fifo_empty && head_ok) begin
                    pop       = 1'b1;
                    load_cur  = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered tile-bus outputs and status pulses. done follows any
    // cycle in which a real command was on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.risk_func     <= FUNC_NOP;
            bus.risk_reg      <= '0;
            bus.risk_addr     <= '0;
            bus.risk_stride_x <= '0;
            bus.risk_stride_y <= '0;
            bus.done          <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            if (issue) begin
                bus.risk_func     <= cur.func;
                bus.risk_reg      <= cur.rg;
                bus.risk_addr     <= cur.addr;
                bus.risk_stride_x <= cur.stride_x;
                bus.risk_stride_y <= cur.stride_y;
            end else begin
                bus.risk_func <= FUNC_NOP;
            end
            bus.done <= (bus.risk_func != FUNC_NOP);
            bus.err  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_risk_ctrl.sv
// Testbench for risk_ctrl: directed scenarios plus a randomized command
// stream, checked against a transaction-level queue model of the expected
// issue order, done/err counts and store-hold behaviour.
module tb_risk_ctrl;
    localparam int SZ     = 4;
    localparam int LOGCNT = 5;
    localparam int DEPTH  = 4;
    localparam int AW     = 10 + LOGCNT;
    localparam int SW     = 9 + LOGCNT;

    localparam logic [2:0] LOAD  = 3'b000;
    localparam logic [2:0] STORE = 3'b001;
    localparam logic [2:0] ZERO  = 3'b010;
    localparam logic [2:0] NOP   = 3'b111;

    typedef struct packed {
        logic [2:0]    func;
        logic [4:0]    rg;
        logic [AW-1:0] addr;
        logic [SW-1:0] sx;
        logic [SW-1:0] sy;
    } cmd_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    risk_ctrl_if #(.LOGCNT(LOGCNT)) bus ();

    risk_ctrl #(.SZ(SZ), .LOGCNT(LOGCNT), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp    = 0;
    int   n_mis    = 0;
    cmd_t exp_q[$];
    int   exp_done = 0;
    int   exp_err  = 0;
    int   n_done   = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   first_act = -1;
    int   last_act  = -1;
    int   done_cyc  = -1;
    bit   prev_store = 1'b0;
    bit   saw_full   = 1'b0;
    cmd_t hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then observe the registered outputs 1 time unit later.
    task automatic tick();
        cmd_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done === 1'b1) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (bus.err === 1'b1) n_err++;
        if (bus.cmd_ready === 1'b0) saw_full = 1'b1;
        if (prev_store) begin
            check("store_hold_nop", 32'(bus.risk_func), 32'(NOP));
            check("store_hold_addr", 32'(bus.risk_addr), 32'(hold.addr));
        end
        prev_store = 1'b0;
        if (bus.risk_func !== NOP) begin
            if (first_act < 0) first_act = cyc;
            last_act = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 32'(bus.risk_func), 32'(NOP));
            end else begin
                e = exp_q.pop_front();
                check("issue_func", 32'(bus.risk_func), 32'(e.func));
                check("issue_reg", 32'(bus.risk_reg), 32'(e.rg));
                check("issue_addr", 32'(bus.risk_addr), 32'(e.addr));
                check("issue_sx", 32'(bus.risk_stride_x), 32'(e.sx));
                check("issue_sy", 32'(bus.risk_stride_y), 32'(e.sy));
                if (e.func == STORE) begin
                    prev_store = 1'b1;
                    hold       = e;
                end
            end
        end
    endtask

    // Offer one command, wait (bounded) for room, and record the expectation.
    task automatic push(input logic [2:0] f, input logic [4:0] r, input logic [AW-1:0] a,
                        input logic [SW-1:0] sx, input logic [SW-1:0] sy);
        cmd_t c;
        int   guard;
        guard = 0;
        c = '{f, r, a, sx, sy};
        bus.cmd_valid    = 1'b1;
        bus.cmd_func     = f;
        bus.cmd_reg      = r;
        bus.cmd_addr     = a;
        bus.cmd_stride_x = sx;
        bus.cmd_stride_y = sy;
        while (bus.cmd_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("push_timeout", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        if (f <= 3'd2 && r <= 5'd2) begin
            exp_q.push_back(c);
            exp_done++;
        end else begin
            exp_err++;
        end
    endtask

    // Run until every expected command has appeared and the controller is idle.
    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && guard < 500) begin
            tick();
            guard++;
        end
        check("drain_in_time", 32'(guard < 500), 32'd1);
        tick();
        tick();
    endtask

    task automatic mark();
        first_act = -1;
        last_act  = -1;
        done_cyc  = -1;
    endtask

    initial begin
        int n_edge;
        int err0;
        int done0;

        bus.cmd_valid    = 1'b0;
        bus.cmd_func     = '0;
        bus.cmd_reg      = '0;
        bus.cmd_addr     = '0;
        bus.cmd_stride_x = '0;
        bus.cmd_stride_y = '0;

        // Reset values
        #12;
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_func", 32'(bus.risk_func), 32'(NOP));
        check("rst_reg", 32'(bus.risk_reg), 32'd0);
        check("rst_addr", 32'(bus.risk_addr), 32'd0);
        check("rst_sx", 32'(bus.risk_stride_x), 32'd0);
        check("rst_sy", 32'(bus.risk_stride_y), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single zero: latency N+2, one-cycle issue, done after it, idle afterwards
        mark();
        push(ZERO, 5'd0, AW'(0), SW'(1), SW'(1));
        n_edge = cyc;
        check("zero_busy_after_push", 32'(bus.busy), 32'd1);
        drain();
        check("zero_latency", 32'(first_act), 32'(n_edge + 2));
        check("zero_one_cycle", 32'(last_act - first_act), 32'd0);
        check("zero_done_cycle", 32'(done_cyc), 32'(n_edge + 3));
        check("zero_busy_idle", 32'(bus.busy), 32'd0);

        // Store then load: 001, NOP with addr held, 000
        mark();
        push(STORE, 5'd0, AW'('h10), SW'(1), SW'(1));
        push(LOAD, 5'd1, AW'('h10), SW'(1), SW'(1));
        drain();
        check("st_ld_span", 32'(last_act - first_act), 32'd2);
        check("st_ld_done", 32'(n_done), 32'(exp_done));

        // Back-to-back loads/zeros: one per cycle
        mark();
        for (int i = 0; i < 4; i++)
            push((i % 2 == 0) ? LOAD : ZERO, 5'(i % 3), AW'($urandom), SW'($urandom), SW'($urandom));
        drain();
        check("load_rate_span", 32'(last_act - first_act), 32'd3);

        // Back-to-back stores: one per two cycles
        mark();
        for (int i = 0; i < 3; i++)
            push(STORE, 5'(i), AW'($urandom), SW'($urandom), SW'($urandom));
        drain();
        check("store_rate_span", 32'(last_act - first_act), 32'd4);

        // Fill: leading stores throttle the consumer until the FIFO fills
        saw_full = 1'b0;
        for (int i = 0; i < 2 * DEPTH; i++)
            push(STORE, 5'd2, AW'($urandom), SW'($urandom), SW'($urandom));
        for (int i = 0; i < DEPTH + 1; i++)
            push(LOAD, 5'd1, AW'(100 + i), SW'(i), SW'(i + 1));
        drain();
        check("fill_saw_not_ready", 32'(saw_full), 32'd1);
        check("fill_done", 32'(n_done), 32'(exp_done));

        // Invalid commands interleaved with valid loads
        err0 = n_err;
        push(LOAD, 5'd0, AW'('h21), SW'(2), SW'(3));
        push(3'b011, 5'd0, AW'('h22), SW'(2), SW'(3));
        push(LOAD, 5'd1, AW'('h23), SW'(2), SW'(3));
        push(LOAD, 5'd3, AW'('h24), SW'(2), SW'(3));
        push(LOAD, 5'd2, AW'('h25), SW'(2), SW'(3));
        drain();
        check("inv_err_pulses", 32'(n_err - err0), 32'd2);
        check("inv_err_total", 32'(n_err), 32'(exp_err));
        check("inv_done_total", 32'(n_done), 32'(exp_done));

        // Reset during STORE_HOLD with three loads queued
        push(STORE, 5'd0, AW'('h31), SW'(1), SW'(1));
        push(STORE, 5'd1, AW'('h32), SW'(1), SW'(1));
        push(LOAD, 5'd0, AW'('h33), SW'(1), SW'(1));
        push(LOAD, 5'd1, AW'('h34), SW'(1), SW'(1));
        push(LOAD, 5'd2, AW'('h35), SW'(1), SW'(1));
        check("mid_store_on_bus", 32'(bus.risk_func), 32'(STORE));
        check("mid_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_func", 32'(bus.risk_func), 32'(NOP));
        check("arst_reg", 32'(bus.risk_reg), 32'd0);
        check("arst_addr", 32'(bus.risk_addr), 32'd0);
        check("arst_sx", 32'(bus.risk_stride_x), 32'd0);
        check("arst_sy", 32'(bus.risk_stride_y), 32'd0);
        check("arst_ready", 32'(bus.cmd_ready), 32'd1);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        exp_q.delete();
        prev_store = 1'b0;
        @(posedge clk);
        #1;
        check("arst_hold_func", 32'(bus.risk_func), 32'(NOP));
        @(negedge clk);
        reset = 1'b0;
        done0 = n_done;
        err0  = n_err;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_func", 32'(bus.risk_func), 32'(NOP));
            check("post_rst_busy", 32'(bus.busy), 32'd0);
        end
        check("post_rst_no_done", 32'(n_done - done0), 32'd0);
        check("post_rst_no_err", 32'(n_err - err0), 32'd0);

        // Randomized stream with random gaps
        n_done = 0; n_err = 0; exp_done = 0; exp_err = 0;
        for (int i = 0; i < 80; i++) begin
            logic [2:0] f;
            logic [4:0] r;
            int         sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3)      f = LOAD;
            else if (sel <= 5) f = STORE;
            else if (sel <= 7) f = ZERO;
            else if (sel == 8) f = 3'b011;
            else               f = 3'($urandom_range(4, 7));
            r = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(3, 31)) : 5'($urandom_range(0, 2));
            push(f, r, AW'($urandom), SW'($urandom), SW'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        check("rand_done_total", 32'(n_done), 32'(exp_done));
        check("rand_err_total", 32'(n_err), 32'(exp_err));
        check("rand_final_busy", 32'(bus.busy), 32'd0);
        check("rand_final_ready", 32'(bus.cmd_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
